bcd_convert_seq: RTL and testbench

Sequential binary-to-BCD converter that feeds the six-digit dynamic seven-segment display path. It accepts an unsigned binary value from the counter or measurement logic and produces six packed BCD digits using iterative shift-add-3 (double dabble), one bit per clock. Results are held stable between conversions so the digit scanner downstream never sees intermediate values. An optional leading-zero blanking mask is also produced.

---
 rtl/bcd_convert_seq.sv | 140 ++++++++++++++
 tb/tb_bcd_convert_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock) with held outputs.
// Define BCD_BLANK_LEAD_EN to build the leading-zero blanking mask; otherwise blank is tied to zero.
module bcd_convert_seq #(
    parameter int IN_W   = 20,
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [IN_W-1:0]     bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // 10^DIGITS - 1 evaluated modulo 2^IN_W; exact because the result fits in IN_W bits.
    function automatic logic [IN_W-1:0] max_bcd_value(input int n);
        logic [IN_W-1:0] p;
        p = {{(IN_W-1){1'b0}}, 1'b1};
        for (int k = 0; k < n; k++) begin
            p = (p << 3) + (p << 1);
        end
        return p - {{(IN_W-1){1'b0}}, 1'b1};
    endfunction

    localparam logic [IN_W-1:0] MAX_VAL = max_bcd_value(DIGITS);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IN_W-1:0]       r_sr;
    logic [BCD_W-1:0]      r_work;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_over;
    logic [BCD_W-1:0]      w_adj;
    logic [BCD_W+IN_W-1:0] w_cat;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_over   = (bin_in > MAX_VAL);

    // Per-digit add-3 correction, no carry between digits.
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_cat = {w_adj, r_sr} << 1;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_work <= '0;
            r_ovf  <= w_over;
            r_sr   <= w_over ? MAX_VAL : bin_in;
        end else if (r_state == S_SHIFT) begin
            {r_work, r_sr} <= w_cat;
        end
    end

    // Control FSM; busy stays high through the cycle in which done is visible.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= CNT_W'(IN_W);
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_out <= r_work;
                    ovf     <= r_ovf;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BCD_BLANK_LEAD_EN
    logic [DIGITS-1:0] w_blank;

    // Digit i goes dark while it and every higher digit are zero; digit 0 is always lit.
    always_comb begin
        logic run;
        w_blank = '0;
        run     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run        = run && (r_work[4*i +: 4] == 4'd0);
            w_blank[i] = run;
        end
        if (r_ovf) begin
            w_blank = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (r_state == S_DONE) begin
            blank <= w_blank;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: table of conversions plus handshake and abort sequences.
module tb_bcd_convert_seq;
    logic        clk;
    logic        rstn;
    logic        start;
    logic [19:0] bin_in;
    logic        busy;
    logic        done;
    logic [23:0] bcd_out;
    logic        ovf;
    logic [5:0]  blank;

`ifdef BCD_BLANK_LEAD_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    bcd_convert_seq #(.IN_W(20), .DIGITS(6)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  blank;
    } exp_t;

    typedef struct {
        logic [19:0] bin;
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  blank;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        int   c;
        e.ovf   = (v > 999999);
        c       = e.ovf ? 999999 : v;
        e.bcd   = '0;
        e.blank = '0;
        for (int i = 0; i < 6; i++) begin
            e.bcd[4*i +: 4] = 4'(c % 10);
            c = c / 10;
        end
        if (BLANK_ON && !e.ovf) begin
            for (int i = 5; i >= 1; i--) begin
                if (e.bcd[4*i +: 4] != 4'd0) break;
                e.blank[i] = 1'b1;
            end
        end
        return e;
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (rstn === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_bcd", 32'(bcd_out), 32'(e.bcd));
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
                check("sb_blank", 32'(blank), 32'(e.blank));
            end
        end
    end

    task automatic run_conv(input logic [19:0] v, input exp_t e, input string tag);
        int          n;
        bit          stable;
        logic [23:0] prev;
        @(negedge clk);
        prev   = bcd_out;
        start  = 1'b1;
        bin_in = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n      = 0;
        stable = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (bcd_out !== prev) stable = 1'b0;
        end
        check({tag, "_latency"}, 32'(n), 32'd21);
        check({tag, "_held_while_busy"}, 32'(stable), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    vec_t tbl[11];

    initial begin
        int   nd;
        int   n;
        int   t[3];
        exp_t e;

        tbl[0]  = '{20'd123456,  24'h123456, 1'b0, 6'b000000};
        tbl[1]  = '{20'd0,       24'h000000, 1'b0, 6'b111110};
        tbl[2]  = '{20'd999999,  24'h999999, 1'b0, 6'b000000};
        tbl[3]  = '{20'd1000000, 24'h999999, 1'b1, 6'b000000};
        tbl[4]  = '{20'd1048575, 24'h999999, 1'b1, 6'b000000};
        tbl[5]  = '{20'd42,      24'h000042, 1'b0, 6'b111100};
        tbl[6]  = '{20'd100000,  24'h100000, 1'b0, 6'b000000};
        tbl[7]  = '{20'd5,       24'h000005, 1'b0, 6'b111110};
        tbl[8]  = '{20'd90,      24'h000090, 1'b0, 6'b111100};
        tbl[9]  = '{20'd500000,  24'h500000, 1'b0, 6'b000000};
        tbl[10] = '{20'd65536,   24'h065536, 1'b0, 6'b100000};

        rstn   = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_blank", 32'(blank), 32'(BLANK_ON ? 6'b111110 : 6'b000000));
        rstn = 1'b0;

        for (int i = 0; i < 11; i++) begin
            e.bcd   = tbl[i].bcd;
            e.ovf   = tbl[i].ovf;
            e.blank = BLANK_ON ? tbl[i].blank : 6'b000000;
            run_conv(tbl[i].bin, e, $sformatf("vec%0d", i));
        end

        // start pulses sampled mid-SHIFT and in the DONE state must be dropped
        @(negedge clk);
        start  = 1'b1;
        bin_in = 20'd314159;
        sb.push_back(model(314159));
        @(posedge clk);
        nd = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start  = (k == 5 || k == 21);
            bin_in = 20'(k);
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        start = 1'b0;
        check("ignore_single_done", 32'(nd), 32'd1);
        check("ignore_idle_busy", 32'(busy), 32'd0);

        // start held high: back-to-back conversions
        @(negedge clk);
        for (int k = 0; k < 3; k++) sb.push_back(model(271828));
        start  = 1'b1;
        bin_in = 20'd271828;
        @(posedge clk);
        n  = 0;
        nd = 0;
        t  = '{0, 0, 0};
        while (n < 100 && nd < 3) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                t[nd] = n;
                nd++;
            end
        end
        start = 1'b0;
        check("hold_count", 32'(nd), 32'd3);
        check("hold_first", 32'(t[0]), 32'd21);
        check("hold_gap1", 32'(t[1] - t[0]), 32'd22);
        check("hold_gap2", 32'(t[2] - t[1]), 32'd22);
        repeat (2) @(posedge clk);
        #1;
        check("hold_idle_busy", 32'(busy), 32'd0);

        // reset ten cycles into a conversion aborts it
        @(negedge clk);
        start  = 1'b1;
        bin_in = 20'd777777;
        sb.push_back(model(777777));
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_blank", 32'(blank), 32'(BLANK_ON ? 6'b111110 : 6'b000000));
        @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        run_conv(20'd42, model(42), "after_abort");

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
